liteic_rd_arbiter: RTL
======================

# liteic_rd_arbiter

Per-slave-slot read-channel arbiter for the liteic AXI-lite interconnect. It shares one slave port's AR channel among `NUM_MST` masters, using QoS priority with a round-robin tie-break. It records the owner of each accepted read in an in-order owner FIFO and routes R beats back to that master. The block sits between the master-side AR/R channels and one registered slave slot.

## Interface
- `NUM_MST`, 4: number of requesting masters (2..8).
- `ADDR_WIDTH`, 32: AR address width.
- `DATA_WIDTH`, 32: R data width.
- `RESP_WIDTH`, 2: R response width.
- `QOS_WIDTH`, 4: AR QoS width.
- `MAX_OUT`, 4: owner FIFO depth, i.e. the maximum number of outstanding reads (power of 2).
- `clk_i` in 1: single clock, rising edge.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `mst_ar_addr_i` in `NUM_MST*ADDR_WIDTH`: packed per-master AR address; master m occupies slice m.
- `mst_ar_qos_i` in `NUM_MST*QOS_WIDTH`: packed per-master QoS.
- `mst_ar_valid_i` in `NUM_MST`: per-master AR valid.
- `mst_ar_ready_o` out `NUM_MST`: per-master AR ready; one-hot or zero.
- `mst_r_data_o` out `DATA_WIDTH`: R data, broadcast to all masters.
- `mst_r_resp_o` out `RESP_WIDTH`: R response, broadcast.
- `mst_r_valid_o` out `NUM_MST`: per-master R valid; one-hot or zero.
- `mst_r_ready_i` in `NUM_MST`: per-master R ready.
- `slv_ar_addr_o` out `ADDR_WIDTH`: registered AR address to the slave.
- `slv_ar_qos_o` out `QOS_WIDTH`: registered AR QoS.
- `slv_ar_valid_o` out 1: registered AR valid.
- `slv_ar_ready_i` in 1: slave AR ready.
- `slv_r_data_i` in `DATA_WIDTH`, `slv_r_resp_i` in `RESP_WIDTH`, `slv_r_valid_i` in 1: slave R channel.
- `slv_r_ready_o` out 1: R ready to the slave.
- `out_cnt_o` out `$clog2(MAX_OUT)+1`: current number of outstanding reads.

## Operation
- **AR stage:** a single output register (addr, qos, valid) that holds the granted request until `slv_ar_valid_o && slv_ar_ready_i`.
- **Stage free:** `free = !slv_ar_valid_o || slv_ar_ready_i`.
- **Grant enable:** `free && (out_cnt_o < MAX_OUT) && |mst_ar_valid_i`. The full check uses the registered count only; a same-cycle R pop does not unblock a grant.
- **Grant selection:**
  - Among valid masters, pick the one with the highest `mst_ar_qos_i` (unsigned).
  - Break ties with round-robin: search order starts at `rr_ptr+1` and wraps modulo `NUM_MST`.
- **On grant g (combinational within the cycle):**
  - `mst_ar_ready_o[g]=1`.
  - Load g's addr/qos into the AR stage and set `slv_ar_valid_o`.
  - Push g into the owner FIFO.
  - Set `rr_ptr<=g`.
- **No grant:**
  - All `mst_ar_ready_o=0`.
  - If the slave accepted this cycle, clear `slv_ar_valid_o`; otherwise hold the stage unchanged.
- **R routing:** a combinational passthrough keyed on the FIFO head h, valid only when the FIFO is not empty.
  - `mst_r_valid_o[h]=slv_r_valid_i`; all other bits 0.
  - `slv_r_ready_o=mst_r_ready_i[h]`.
  - Data and resp pass straight through.
- **Pop:** on `slv_r_valid_i && slv_r_ready_o`.
- **FIFO empty:** `slv_r_ready_o=0` and all `mst_r_valid_o=0`. A stray slave R beat stalls; it is never dropped or misrouted.
- **Count:** `out_cnt_o` increments on push and decrements on pop. A same-cycle push and pop leaves it unchanged.
- **Ordering:** responses are returned strictly in AR acceptance order. The slave is required to respond in order.
- **Reset values (asynchronous assert):**
  - `slv_ar_valid_o=0`, `slv_ar_addr_o=0`, `slv_ar_qos_o=0`.
  - `rr_ptr=NUM_MST-1`, so master 0 wins the first tie.
  - FIFO pointers 0, `out_cnt_o=0`.
  - All `mst_ar_ready_o`, `mst_r_valid_o` and `slv_r_ready_o` are 0.
- **Reset mid-operation:** all in-flight ownership is discarded. Masters and slave are reset together.

## Timing
- **AR latency:** a grant in cycle T puts the request on `slv_ar_*` from T+1.
- **AR throughput:** one grant per cycle when the slave holds `slv_ar_ready_i=1` and the FIFO is not full.
- **AR hold:** while `slv_ar_ready_i=0`, the AR stage holds addr/qos/valid stable and no new grant occurs (AXI valid-stable rule).
- **R path:** zero latency, combinational from slave to master. `slv_r_ready_o` depends on the head master's ready only.
- **Ready/valid dependency:** `mst_ar_ready_o` may depend on `mst_ar_valid_i`, which is legal for AXI-lite ready. No valid output depends on a ready input.
- **Full boundary:** with `out_cnt_o==MAX_OUT`, no grant is issued, even if a pop occurs in the same cycle. The earliest grant after that pop is the following cycle.
- **Count width:** `out_cnt_o` covers 0..`MAX_OUT` inclusive. FIFO pointers wrap modulo `MAX_OUT`.

## Test plan
- **Reset:** assert `rstn_i` low asynchronously mid-cycle with `slv_ar_valid_o=1` -> all outputs 0 immediately and `out_cnt_o=0`. After release, masters 0 and 2 request with equal qos -> master 0 is granted first.
- **QoS priority:** masters 1 (qos=3) and 3 (qos=9) request together, slave ready=1 -> grant master 3 at T; `slv_ar_addr_o`=M3 addr at T+1; master 1 granted at T+1.
- **Round-robin:** all 4 masters request, qos=0, held continuously, slave always ready -> grant order 0,1,2,3,0 on consecutive cycles.
- **Backpressure and full:** `slv_ar_ready_i=0` for 5 cycles -> stage holds; accept 4 reads with no R -> `out_cnt_o=4` and the fifth master stalls. One R pop -> the fifth master is granted the next cycle.
- **R routing:** reads granted to masters 2,0,2; slave returns data 0xA,0xB,0xC -> `mst_r_valid_o` one-hot at bits 2,0,2 in order. `mst_r_ready_i[0]=0` for 3 cycles -> `slv_r_ready_o=0` and data 0xB is held.
- **Stray beat:** `slv_r_valid_i=1` with the FIFO empty -> `slv_r_ready_o=0`, no `mst_r_valid_o` asserted, count unchanged.

Source files
------------

// File: rtl/liteic_rd_arbiter.sv
// rtl/liteic_rd_arbiter.sv - AR arbiter (QoS + round-robin) with in-order R owner routing
module liteic_rd_arbiter #(
    parameter int NUM_MST    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_WIDTH = 2,
    parameter int QOS_WIDTH  = 4,
    parameter int MAX_OUT    = 4
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic [NUM_MST*ADDR_WIDTH-1:0]   mst_ar_addr_i,
    input  logic [NUM_MST*QOS_WIDTH-1:0]    mst_ar_qos_i,
    input  logic [NUM_MST-1:0]              mst_ar_valid_i,
    output logic [NUM_MST-1:0]              mst_ar_ready_o,
    output logic [DATA_WIDTH-1:0]           mst_r_data_o,
    output logic [RESP_WIDTH-1:0]           mst_r_resp_o,
    output logic [NUM_MST-1:0]              mst_r_valid_o,
    input  logic [NUM_MST-1:0]              mst_r_ready_i,
    output logic [ADDR_WIDTH-1:0]           slv_ar_addr_o,
    output logic [QOS_WIDTH-1:0]            slv_ar_qos_o,
    output logic                            slv_ar_valid_o,
    input  logic                            slv_ar_ready_i,
    input  logic [DATA_WIDTH-1:0]           slv_r_data_i,
    input  logic [RESP_WIDTH-1:0]           slv_r_resp_i,
    input  logic                            slv_r_valid_i,
    output logic                            slv_r_ready_o,
    output logic [$clog2(MAX_OUT):0]        out_cnt_o
);
    localparam int IDX_W = $clog2(NUM_MST);
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     cand;
    logic [QOS_WIDTH-1:0] cand_qos;
    logic [QOS_WIDTH-1:0] best_qos;
    logic                 found;
    logic                 stage_free;
    logic                 grant_en;
    logic                 fifo_empty;
    logic                 pop;
    logic [IDX_W-1:0]     head_idx;
    logic [IDX_W-1:0]     owner_mem [MAX_OUT];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;

    // Scan starts just after the last winner; strict '>' keeps the earliest tie in scan order.
    always_comb begin
        grant_idx = rr_ptr;
        best_qos  = '0;
        found     = 1'b0;
        cand      = '0;
        cand_qos  = '0;
        for (int i = 1; i <= NUM_MST; i++) begin
            cand     = IDX_W'((int'(rr_ptr) + i) % NUM_MST);
            cand_qos = mst_ar_qos_i[int'(cand)*QOS_WIDTH +: QOS_WIDTH];
            if (mst_ar_valid_i[cand] && (!found || cand_qos > best_qos)) begin
                found     = 1'b1;
                grant_idx = cand;
                best_qos  = cand_qos;
            end
        end
    end

    assign stage_free     = !slv_ar_valid_o || slv_ar_ready_i;
    assign grant_en       = rstn_i && stage_free && (out_cnt_o < CNT_W'(MAX_OUT)) && (|mst_ar_valid_i);
    assign mst_ar_ready_o = grant_en ? (NUM_MST'(1) << grant_idx) : '0;

    assign fifo_empty    = (out_cnt_o == '0);
    assign head_idx      = owner_mem[rd_ptr];
    assign mst_r_valid_o = (!fifo_empty && slv_r_valid_i) ? (NUM_MST'(1) << head_idx) : '0;
    assign slv_r_ready_o = !fifo_empty && mst_r_ready_i[head_idx];
    assign mst_r_data_o  = slv_r_data_i;
    assign mst_r_resp_o  = slv_r_resp_i;
    assign pop           = slv_r_valid_i && slv_r_ready_o;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            slv_ar_valid_o <= 1'b0;
            slv_ar_addr_o  <= '0;
            slv_ar_qos_o   <= '0;
            rr_ptr         <= IDX_W'(NUM_MST - 1);
        end else if (grant_en) begin
            slv_ar_valid_o <= 1'b1;
            slv_ar_addr_o  <= mst_ar_addr_i[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            slv_ar_qos_o   <= mst_ar_qos_i[int'(grant_idx)*QOS_WIDTH +: QOS_WIDTH];
            rr_ptr         <= grant_idx;
        end else if (slv_ar_ready_i) begin
            slv_ar_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_cnt_o <= '0;
        end else begin
            if (grant_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            case ({grant_en, pop})
                2'b10:   out_cnt_o <= out_cnt_o + 1'b1;
                2'b01:   out_cnt_o <= out_cnt_o - 1'b1;
                default: out_cnt_o <= out_cnt_o;
            endcase
        end
    end

    // Owner slots are only read behind the count, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (grant_en) owner_mem[wr_ptr] <= grant_idx;
    end

endmodule
